// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, write-through register file, decoder,
// branch/jump resolution and RAW/load-use stall generation.
module id_stage #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_in,
   input  logic [31:0] Instruction_in,
   input  logic        WB_en,
   input  logic [4:0]  WB_dest,
   input  logic [31:0] WB_value,
   input  logic        EXE_WB_en,
   input  logic [4:0]  EXE_dest,
   input  logic        MEM_WB_en,
   input  logic [4:0]  MEM_dest,
   output logic        freeze,
   output logic        Branch_taken,
   output logic [31:0] BranchAddr,
   output logic [31:0] PC_out,
   output logic [31:0] Val1,
   output logic [31:0] Val2,
   output logic [31:0] Imm,
   output logic [4:0]  Dest,
   output logic [3:0]  EXE_CMD,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic        Imm_sel
);
   localparam int AW = $clog2(NUM_REGS);

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23;
   localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;
   localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
   localparam logic [3:0] CMD_ADD = 4'd0, CMD_SUB = 4'd1, CMD_AND = 4'd2, CMD_OR = 4'd3, CMD_SLT = 4'd4;

   logic [31:0] pc_q, pc_d, inst_q, inst_d;
   logic [31:0] regs_q [NUM_REGS];
   logic [31:0] regs_d [NUM_REGS];

   logic [5:0]  op_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s, dest_s;
   logic [3:0]  exe_cmd_s, r_cmd_s;
   logic        r_ok_s, wb_s, mem_r_s, mem_w_s, imm_sel_s;
   logic        use_rs_s, use_rt_s, is_beq_s, is_bne_s, is_j_s;
   logic [31:0] val1_s, val2_s, imm_ext_s, br_addr_s;
   logic        hazard_s, taken_s;

   // A source depends on an in-flight writer when it is read, nonzero and matches.
   function automatic logic dep(input logic used, input logic [4:0] src,
                                input logic en, input logic [4:0] dst);
      return used && (src != 5'd0) && en && (dst == src);
   endfunction

   assign op_s      = inst_q[31:26];
   assign rs_s      = inst_q[25:21];
   assign rt_s      = inst_q[20:16];
   assign rd_s      = inst_q[15:11];
   assign funct_s   = inst_q[5:0];
   assign imm_ext_s = {{16{inst_q[15]}}, inst_q[15:0]};

   // Instruction decode into raw controls and source usage.
   always_comb begin
      exe_cmd_s = CMD_ADD;
      r_cmd_s   = CMD_ADD;
      r_ok_s    = 1'b0;
      wb_s      = 1'b0;
      mem_r_s   = 1'b0;
      mem_w_s   = 1'b0;
      imm_sel_s = 1'b0;
      dest_s    = 5'd0;
      use_rs_s  = 1'b0;
      use_rt_s  = 1'b0;
      is_beq_s  = 1'b0;
      is_bne_s  = 1'b0;
      is_j_s    = 1'b0;
      case (op_s)
         OP_RTYPE: begin
            case (funct_s)
               F_ADD:   begin r_cmd_s = CMD_ADD; r_ok_s = 1'b1; end
               F_SUB:   begin r_cmd_s = CMD_SUB; r_ok_s = 1'b1; end
               F_AND:   begin r_cmd_s = CMD_AND; r_ok_s = 1'b1; end
               F_OR:    begin r_cmd_s = CMD_OR;  r_ok_s = 1'b1; end
               F_SLT:   begin r_cmd_s = CMD_SLT; r_ok_s = 1'b1; end
               default: begin r_cmd_s = CMD_ADD; r_ok_s = 1'b0; end
            endcase
            if (r_ok_s) begin
               exe_cmd_s = r_cmd_s;
               wb_s      = 1'b1;
               dest_s    = rd_s;
               use_rs_s  = 1'b1;
               use_rt_s  = 1'b1;
            end else begin
               exe_cmd_s = CMD_ADD;
            end
         end
         OP_ADDI: begin imm_sel_s = 1'b1; wb_s = 1'b1; dest_s = rt_s; use_rs_s = 1'b1; end
         OP_LW:   begin imm_sel_s = 1'b1; wb_s = 1'b1; mem_r_s = 1'b1; dest_s = rt_s; use_rs_s = 1'b1; end
         OP_SW:   begin imm_sel_s = 1'b1; mem_w_s = 1'b1; use_rs_s = 1'b1; use_rt_s = 1'b1; end
         OP_BEQ:  begin is_beq_s = 1'b1; use_rs_s = 1'b1; use_rt_s = 1'b1; end
         OP_BNE:  begin is_bne_s = 1'b1; use_rs_s = 1'b1; use_rt_s = 1'b1; end
         OP_J:    begin is_j_s = 1'b1; end
         default: begin exe_cmd_s = CMD_ADD; end
      endcase
   end

   // Register-file reads; a same-cycle write-back to the read index is passed through.
   always_comb begin
      if (rs_s == 5'd0)                        val1_s = 32'd0;
      else if (WB_en && (WB_dest == rs_s))     val1_s = WB_value;
      else                                     val1_s = regs_q[rs_s];
      if (rt_s == 5'd0)                        val2_s = 32'd0;
      else if (WB_en && (WB_dest == rt_s))     val2_s = WB_value;
      else                                     val2_s = regs_q[rt_s];
   end

   assign hazard_s = dep(use_rs_s, rs_s, EXE_WB_en, EXE_dest) | dep(use_rs_s, rs_s, MEM_WB_en, MEM_dest)
                   | dep(use_rt_s, rt_s, EXE_WB_en, EXE_dest) | dep(use_rt_s, rt_s, MEM_WB_en, MEM_dest);

   // Branch/jump resolution; suppressed while stalled since operands may be stale.
   always_comb begin
      taken_s   = 1'b0;
      br_addr_s = 32'd0;
      if (hazard_s) begin
         taken_s   = 1'b0;
         br_addr_s = 32'd0;
      end else if (is_j_s) begin
         taken_s   = 1'b1;
         br_addr_s = {pc_q[31:28], inst_q[25:0], 2'b00};
      end else if ((is_beq_s && (val1_s == val2_s)) || (is_bne_s && (val1_s != val2_s))) begin
         taken_s   = 1'b1;
         br_addr_s = pc_q + {imm_ext_s[29:0], 2'b00};
      end else begin
         taken_s   = 1'b0;
         br_addr_s = 32'd0;
      end
   end

   // IF/ID next state: a redirect squashes the wrong-path fetch, a stall holds.
   always_comb begin
      pc_d   = pc_q;
      inst_d = inst_q;
      if (taken_s) begin
         pc_d   = PC_in;
         inst_d = 32'd0;
      end else if (hazard_s) begin
         pc_d   = pc_q;
         inst_d = inst_q;
      end else begin
         pc_d   = PC_in;
         inst_d = Instruction_in;
      end
   end

   // Register-file next state; entry 0 is never written.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = (WB_en && (i != 0) && (WB_dest == AW'(i))) ? WB_value : regs_q[i];
      end
   end

   // IF/ID pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= 32'd0;
         inst_q <= 32'd0;
      end else begin
         pc_q   <= pc_d;
         inst_q <= inst_d;
      end
   end

   // Register-file storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign freeze       = hazard_s;
   assign Branch_taken = taken_s;
   assign BranchAddr   = br_addr_s;
   assign PC_out       = pc_q;
   assign Val1         = val1_s;
   assign Val2         = val2_s;
   assign Imm          = imm_ext_s;
   assign Dest         = dest_s;
   assign EXE_CMD      = hazard_s ? CMD_ADD : exe_cmd_s;
   assign WB_EN        = wb_s & ~hazard_s;
   assign MEM_R_EN     = mem_r_s & ~hazard_s;
   assign MEM_W_EN     = mem_w_s & ~hazard_s;
   assign Imm_sel      = imm_sel_s & ~hazard_s;
endmodule
